fm_sample_scheduler: RTL and testbench
======================================

FM_SAMPLE_SCHEDULER -- requirements
Module: fm_sample_scheduler

Interface
REQ-001 Parameter WIDTH, default 32: sample width, signed two's complement.
REQ-002 Parameter DIV_W, default 16: width of the rate divider.
REQ-003 Parameter LATENCY, default 8: combined FMCore+DeFMCore pipeline depth in cycles, range 1..64.
REQ-004 Ports: clock  in  1  sole clock, all logic on rising edge.
REQ-005 Ports: reset  in  1  asynchronous, active-low reset.
REQ-006 io_start  in  1  begin streaming; io_stop  in  1  end streaming.
REQ-007 io_rate_div  in  DIV_W  issue period minus one, latched at start.
REQ-008 io_in_valid  in  1, io_in_ready  out  1, io_in_value  in  WIDTH: source sample handshake.
REQ-009 io_core_in_value  out  WIDTH: registered drive of the FMCore input.
REQ-010 io_core_out_value  in  WIDTH: DeFMCore output.
REQ-011 io_out_valid  out  1, io_out_value  out  WIDTH: demodulated sample strobe and data, no backpressure.
REQ-012 io_busy  out  1 (state != IDLE); io_underrun  out  16: saturating missed-tick count.

Function
REQ-013 FSM states: IDLE, RUN, DRAIN.
REQ-014 IDLE->RUN on io_start; latch io_rate_div; clear tick counter; clear io_underrun.
REQ-015 io_start outside IDLE is ignored; io_stop in IDLE is ignored.
REQ-016 In RUN, the tick counter counts 0..div and wraps to 0; a tick is the cycle with counter == div.
REQ-017 io_in_ready is 1 only on a tick cycle in RUN; transfer occurs when io_in_valid && io_in_ready.
REQ-018 Transfer: io_core_in_value <= io_in_value on that edge; push 1 into LATENCY-deep valid shift register.
REQ-019 Tick without io_in_valid: io_core_in_value holds; push 0; io_underrun += 1, saturating at 16'hFFFF.
REQ-020 Non-tick cycles push 0 into the shift register.
REQ-021 div = 0: tick every cycle, full-rate issue.
REQ-022 io_out_valid = shift register output, asserted exactly LATENCY+1 cycles after the transfer edge; io_out_value = io_core_out_value in the same cycle, combinationally.
REQ-023 RUN->DRAIN on io_stop; io_stop on a tick cycle suppresses that tick (no transfer, no underrun).
REQ-024 DRAIN: no issue, io_in_ready = 0; shift register keeps shifting; after LATENCY cycles, io_core_in_value <= 0 and state -> IDLE.
REQ-025 io_start during DRAIN is ignored; it is not queued.
REQ-026 In IDLE, io_out_valid = 0 and the shift register is all zero.

Reset
REQ-027 Reset asserted: state IDLE, counters 0, shift register 0, io_core_in_value 0, io_underrun 0, io_in_ready 0, io_out_valid 0, io_busy 0.
REQ-028 Reset mid-RUN/DRAIN aborts immediately; in-flight valids are discarded, with no io_out_valid after release.
REQ-029 After release, first transfer occurs no earlier than div+1 cycles after io_start.

Structure
REQ-030 Shared package fm_pkg: sched_state_e enum, default WIDTH/DIV_W/LATENCY constants, sample typedef.
REQ-031 One sub-module fm_valid_delay: parameterised LATENCY-deep 1-bit shift register with async active-low clear.
REQ-032 FMCore/DeFMCore are instantiated outside; this block only drives and observes them.

Verification
REQ-033 div=4, source always valid, start: transfers on cycles 5,10,15 after start; io_out_valid pulses at each transfer+LATENCY+1.
REQ-034 div=0, 2000-sample sine of amplitude 2^20 through FMCore/DeFMCore: 2000 io_out_valid pulses, io_underrun = 0.
REQ-035 div=3, io_in_valid low for 3 ticks: io_underrun = 3, io_core_in_value unchanged, 3 missing output pulses.
REQ-036 io_stop on a tick cycle: no transfer; exactly LATENCY cycles in DRAIN; io_busy low after; io_core_in_value = 0.
REQ-037 reset low 2 cycles mid-RUN with 5 samples in flight: all outputs 0 within the reset cycle; no io_out_valid after release.
REQ-038 Underrun saturation (div=0, no source for 70000 cycles): io_underrun = 16'hFFFF.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared types and defaults for the FM sample scheduler and its valid-delay line.
package fm_pkg;

   localparam int unsigned FM_WIDTH      = 32;
   localparam int unsigned FM_DIV_W      = 16;
   localparam int unsigned FM_LATENCY    = 8;
   localparam int unsigned FM_UNDERRUN_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } sched_state_e;

   typedef logic signed [FM_WIDTH-1:0] sample_t;

   // Saturating +1 for the missed-tick counter.
   function automatic logic [FM_UNDERRUN_W-1:0] sat_inc(input logic [FM_UNDERRUN_W-1:0] v);
      return (&v) ? v : v + FM_UNDERRUN_W'(1);
   endfunction

endpackage

// File: rtl/fm_valid_delay.sv
// LATENCY-deep 1-bit shift register tracking which core pipeline slots carry a real sample.
module fm_valid_delay #(
   parameter int unsigned LATENCY = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic shift_i,
   output logic valid_o
);

   logic [LATENCY-1:0] sr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= LATENCY'({sr_q, shift_i});
      end
   end

   assign valid_o = sr_q[LATENCY-1];

endmodule

// File: rtl/fm_sample_scheduler.sv
// Paces source samples into the external FMCore/DeFMCore pipeline at a programmable rate
// and strobes the demodulated result when the matching sample emerges.
module fm_sample_scheduler
   import fm_pkg::*;
#(
   parameter int unsigned WIDTH   = FM_WIDTH,
   parameter int unsigned DIV_W   = FM_DIV_W,
   parameter int unsigned LATENCY = FM_LATENCY
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     io_start,
   input  logic                     io_stop,
   input  logic [DIV_W-1:0]         io_rate_div,
   input  logic                     io_in_valid,
   output logic                     io_in_ready,
   input  logic [WIDTH-1:0]         io_in_value,
   output logic [WIDTH-1:0]         io_core_in_value,
   input  logic [WIDTH-1:0]         io_core_out_value,
   output logic                     io_out_valid,
   output logic [WIDTH-1:0]         io_out_value,
   output logic                     io_busy,
   output logic [FM_UNDERRUN_W-1:0] io_underrun
);

   localparam int unsigned DRAIN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   sched_state_e             state_q, state_d;
   logic [DIV_W-1:0]         div_q, div_d;
   logic [DIV_W-1:0]         cnt_q, cnt_d;
   logic [DRAIN_W-1:0]       drain_q, drain_d;
   logic [WIDTH-1:0]         core_in_q, core_in_d;
   logic [FM_UNDERRUN_W-1:0] underrun_q, underrun_d;
   logic                     out_valid_q;
   logic                     tick_c;
   logic                     push_c;
   logic                     dly_valid_c;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         div_q       <= '0;
         cnt_q       <= '0;
         drain_q     <= '0;
         core_in_q   <= '0;
         underrun_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         drain_q     <= drain_d;
         core_in_q   <= core_in_d;
         underrun_q  <= underrun_d;
         out_valid_q <= dly_valid_c;
      end
   end

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      cnt_d      = cnt_q;
      drain_d    = drain_q;
      core_in_d  = core_in_q;
      underrun_d = underrun_q;
      push_c     = 1'b0;
      tick_c     = (state_q == ST_RUN) && (cnt_q == div_q);

      case (state_q)
         ST_IDLE: begin
            if (io_start) begin
               state_d    = ST_RUN;
               div_d      = io_rate_div;
               cnt_d      = '0;
               underrun_d = '0;
            end
         end
         ST_RUN: begin
            // A stop wins over a coincident tick: nothing is issued or counted as missed.
            if (io_stop) begin
               state_d = ST_DRAIN;
               drain_d = '0;
            end else begin
               cnt_d = tick_c ? '0 : cnt_q + DIV_W'(1);
               if (tick_c) begin
                  if (io_in_valid) begin
                     push_c    = 1'b1;
                     core_in_d = io_in_value;
                  end else begin
                     underrun_d = sat_inc(underrun_q);
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (drain_q == DRAIN_W'(LATENCY - 1)) begin
               state_d   = ST_IDLE;
               core_in_d = '0;
            end else begin
               drain_d = drain_q + DRAIN_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   fm_valid_delay #(
      .LATENCY (LATENCY)
   ) u_valid_delay (
      .clk     (clock),
      .rst_n   (reset),
      .shift_i (push_c),
      .valid_o (dly_valid_c)
   );

   assign io_in_ready      = tick_c & ~io_stop;
   assign io_core_in_value = core_in_q;
   assign io_out_valid     = out_valid_q;
   // Data is gated by the strobe so the output bus reads zero whenever no sample is presented.
   assign io_out_value     = out_valid_q ? io_core_out_value : '0;
   assign io_busy          = (state_q != ST_IDLE);
   assign io_underrun      = underrun_q;

endmodule

// File: tb/tb_fm_sample_scheduler.sv
// Directed bench: the driver queues each expected demodulated sample with its arrival cycle,
// a monitor pops and compares on every io_out_valid. The core pair is modelled as a LATENCY-cycle delay.
module tb_fm_sample_scheduler;

   localparam int unsigned W   = 32;
   localparam int unsigned DW  = 16;
   localparam int unsigned LAT = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          io_start = 1'b0;
   logic          io_stop = 1'b0;
   logic [DW-1:0] io_rate_div = '0;
   logic          io_in_valid = 1'b0;
   logic          io_in_ready;
   logic [W-1:0]  io_in_value = '0;
   logic [W-1:0]  io_core_in_value;
   logic [W-1:0]  io_core_out_value;
   logic          io_out_valid;
   logic [W-1:0]  io_out_value;
   logic          io_busy;
   logic [15:0]   io_underrun;

   always #5 clock = ~clock;

   fm_sample_scheduler #(
      .WIDTH   (W),
      .DIV_W   (DW),
      .LATENCY (LAT)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .io_start          (io_start),
      .io_stop           (io_stop),
      .io_rate_div       (io_rate_div),
      .io_in_valid       (io_in_valid),
      .io_in_ready       (io_in_ready),
      .io_in_value       (io_in_value),
      .io_core_in_value  (io_core_in_value),
      .io_core_out_value (io_core_out_value),
      .io_out_valid      (io_out_valid),
      .io_out_value      (io_out_value),
      .io_busy           (io_busy),
      .io_underrun       (io_underrun)
   );

   // Identity FMCore+DeFMCore with LAT cycles of pipeline.
   logic [W-1:0] pipe [LAT];
   always @(posedge clock) begin
      pipe[0] <= io_core_in_value;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign io_core_out_value = pipe[LAT-1];

   typedef struct {
      logic [W-1:0] val;
      int unsigned  cyc;
   } exp_t;

   exp_t        q[$];
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          n_out = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clock) begin : monitor
      exp_t e;
      if (reset === 1'b1 && io_out_valid === 1'b1) begin
         n_out++;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got value 0x%0h, want no strobe (cycle %0d)",
                     io_out_value, cyc);
         end else begin
            e = q.pop_front();
            chk("out_cycle", 64'(cyc), 64'(e.cyc));
            chk("out_value", 64'(io_out_value), 64'(e.val));
         end
      end
   end

   int unsigned ri, tick_n, cur_div;
   logic [W-1:0] exp_core = '0;
   logic [15:0]  exp_under = '0;

   // Inputs change just after the falling edge; they are sampled by the next rising edge.
   task automatic drive(input logic st, input logic sp, input logic v, input logic [W-1:0] val,
                        input logic [DW-1:0] rd);
      @(negedge clock);
      io_start    = st;
      io_stop     = sp;
      io_in_valid = v;
      io_in_value = val;
      io_rate_div = rd;
      #1;
   endtask

   task automatic do_start(input int unsigned div);
      drive(1'b1, 1'b0, 1'b0, '0, DW'(div));
      chk("idle_ready", 64'(io_in_ready), 64'd0);
      chk("idle_busy_pre", 64'(io_busy), 64'd0);
      cur_div   = div;
      ri        = 0;
      tick_n    = 0;
      exp_under = '0;
   endtask

   // Ticks are the cycles ri with ri % (div+1) == div; ticks numbered miss_lo..miss_hi get no source data.
   task automatic run(input int n, input logic [W-1:0] base, input int unsigned miss_lo,
                      input int unsigned miss_hi, input bit poke);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         logic         tk, v;
         logic [W-1:0] val;
         tk  = ((ri % (cur_div + 1)) == cur_div);
         v   = !(tk && tick_n >= miss_lo && tick_n <= miss_hi);
         val = base + ri * 32'h0001_0003;
         drive(poke && (k == 1), 1'b0, v, val, 16'h0077);
         chk("run_ready", 64'(io_in_ready), 64'(tk));
         chk("run_busy", 64'(io_busy), 64'd1);
         chk("run_core_in", 64'(io_core_in_value), 64'(exp_core));
         chk("run_underrun", 64'(io_underrun), 64'(exp_under));
         if (tk) begin
            if (v) begin
               e.val = val;
               e.cyc = cyc + 1 + LAT;
               q.push_back(e);
               exp_core = val;
            end else if (exp_under != 16'hFFFF) begin
               exp_under++;
            end
            tick_n++;
         end
         ri++;
      end
   endtask

   task automatic stop_drain(input bit poke);
      drive(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 16'h0077);
      chk("stop_ready", 64'(io_in_ready), 64'd0);
      for (int j = 0; j < LAT; j++) begin
         drive(poke && (j == 2), 1'b0, 1'b0, '0, 16'h0002);
         chk("drain_busy", 64'(io_busy), 64'd1);
         chk("drain_ready", 64'(io_in_ready), 64'd0);
         chk("drain_core_in", 64'(io_core_in_value), 64'(exp_core));
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      chk("idle_busy", 64'(io_busy), 64'd0);
      chk("idle_core_in", 64'(io_core_in_value), 64'd0);
      chk("idle_out_valid", 64'(io_out_valid), 64'd0);
      chk("idle_underrun", 64'(io_underrun), 64'(exp_under));
      chk("pending_outputs", 64'(q.size()), 64'd0);
      exp_core = '0;
   endtask

   initial begin
      int n0;
      repeat (3) @(negedge clock);
      #1;
      chk("rst_busy", 64'(io_busy), 64'd0);
      chk("rst_ready", 64'(io_in_ready), 64'd0);
      chk("rst_out_valid", 64'(io_out_valid), 64'd0);
      chk("rst_core_in", 64'(io_core_in_value), 64'd0);
      chk("rst_underrun", 64'(io_underrun), 64'd0);
      @(negedge clock);
      reset = 1'b1;

      // div=4: transfers on edges start+5, +10, +15; a start mid-run must not restart the counter.
      do_start(4);
      run(16, 32'd1000, 1, 0, 1'b1);
      stop_drain(1'b1);

      // Stop while idle does nothing.
      drive(1'b0, 1'b1, 1'b0, '0, '0);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      chk("idle_stop_busy", 64'(io_busy), 64'd0);

      // div=1: the stop lands on a tick (ri=5) and must suppress it.
      do_start(1);
      run(5, 32'h0000_5000, 1, 0, 1'b0);
      stop_drain(1'b0);

      // div=3: ticks 1..3 starve; three underruns, three missing strobes.
      n0 = n_out;
      do_start(3);
      run(24, 32'hFFF0_0000, 1, 3, 1'b0);
      stop_drain(1'b0);
      chk("starve_pulses", 64'(n_out - n0), 64'd3);

      // div=0: full-rate issue of 64 signed samples.
      n0 = n_out;
      do_start(0);
      run(64, 32'hFFFF_C000, 1, 0, 1'b0);
      stop_drain(1'b0);
      chk("fullrate_pulses", 64'(n_out - n0), 64'd64);

      // Reset mid-run with 5 samples in flight.
      do_start(0);
      run(5, 32'h1234_0000, 1, 0, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("abort_busy", 64'(io_busy), 64'd0);
      chk("abort_ready", 64'(io_in_ready), 64'd0);
      chk("abort_out_valid", 64'(io_out_valid), 64'd0);
      chk("abort_out_value", 64'(io_out_value), 64'd0);
      chk("abort_core_in", 64'(io_core_in_value), 64'd0);
      chk("abort_underrun", 64'(io_underrun), 64'd0);
      q.delete();
      exp_core  = '0;
      exp_under = '0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      n0 = n_out;
      repeat (20) drive(1'b0, 1'b0, 1'b0, '0, '0);
      chk("post_reset_pulses", 64'(n_out - n0), 64'd0);
      chk("post_reset_busy", 64'(io_busy), 64'd0);

      // No source for 70000 full-rate ticks: counter pins at 16'hFFFF.
      do_start(0);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      repeat (70000) @(negedge clock);
      #1;
      chk("underrun_sat", 64'(io_underrun), 64'hFFFF);
      exp_under = 16'hFFFF;
      stop_drain(1'b0);

      // Restart clears the underrun count; first transfer is div+1 edges after start.
      do_start(2);
      run(9, 32'h0000_0007, 1, 0, 1'b0);
      stop_drain(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
